// File: rtl/nv_ram_rws_16x256_fifo_ctrl.sv
// Valid/ready FIFO controller driving one external 16x256 read/write-separate RAM,
// with a 2-entry output skid so rd_pd holds steady under backpressure.
module nv_ram_rws_16x256_fifo_ctrl #(
  parameter int DW = 256,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic [4:0]    fifo_cnt
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(1 << AW);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   ram_cnt_reg;
  logic          rd_pend_reg;
  logic [1:0]    skid_cnt_reg;
  logic          skid_rp_reg;
  logic          skid_wp_reg;
  logic [DW-1:0] skid_mem_reg [2];

  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    skid_claim;
  logic [1:0]    skid_we;

  assign wr_prdy = !reset && (ram_cnt_reg != RAM_FULL);
  assign push    = wr_pvld && wr_prdy;
  assign rd_pvld = (skid_cnt_reg != 2'd0);
  assign pop     = rd_pvld && rd_prdy;

  // Skid slots already spoken for next cycle: held entries plus the read in flight,
  // minus whatever leaves this cycle. Issuing only below 2 keeps the skid from overflowing.
  assign skid_claim = {1'b0, skid_cnt_reg} + {2'b00, rd_pend_reg} - {2'b00, pop};
  assign issue      = !reset && (ram_cnt_reg != '0) && (skid_claim < 3'd2);

  assign ram_we = push;
  assign ram_wa = wr_ptr_reg;
  assign ram_di = wr_pd;
  assign ram_re = issue;
  assign ram_ra = rd_ptr_reg;

  assign rd_pd    = skid_mem_reg[skid_rp_reg];
  assign fifo_cnt = 5'(ram_cnt_reg) + {4'b0000, rd_pend_reg} + {3'b000, skid_cnt_reg};

  // A read in flight during reset is dropped rather than captured.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_skid_we
      assign skid_we[gi] = !reset && rd_pend_reg && (skid_wp_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (skid_we[i]) skid_mem_reg[i] <= ram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      rd_pend_reg  <= 1'b0;
      skid_cnt_reg <= 2'd0;
      skid_rp_reg  <= 1'b0;
      skid_wp_reg  <= 1'b0;
    end else begin
      if (push)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      ram_cnt_reg  <= ram_cnt_reg + (AW+1)'(push) - (AW+1)'(issue);
      rd_pend_reg  <= issue;
      skid_cnt_reg <= skid_cnt_reg + {1'b0, rd_pend_reg} - {1'b0, pop};
      if (rd_pend_reg) skid_wp_reg <= ~skid_wp_reg;
      if (pop)         skid_rp_reg <= ~skid_rp_reg;
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_16x256_fifo_ctrl.sv
// Bench for the RAM-backed FIFO controller: a behavioural RAM plus a queue model of FIFO order.
module tb_nv_ram_rws_16x256_fifo_ctrl;

  localparam int DW = 256;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic [4:0]    fifo_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_q[$];

  always #5 clk = ~clk;

  nv_ram_rws_16x256_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
    .fifo_cnt(fifo_cnt)
  );

  // External RAM: registered read address, combinational data out.
  logic [DW-1:0] ram_mem [16];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = ram_mem[ra_q];

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Inputs change just after posedge; outputs are sampled at the following negedge.
  task automatic drive(input logic wv, input logic [DW-1:0] d, input logic rp);
    wr_pvld = wv;
    wr_pd   = d;
    rd_prdy = rp;
    @(negedge clk);
  endtask

  task automatic commit();
    if (reset) model_q.delete();
    else begin
      if (rd_pvld && rd_prdy) void'(model_q.pop_front());
      if (wr_pvld && wr_prdy) model_q.push_back(wr_pd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, rand_word(), 1'b0);
    checks++; if (wr_prdy !== 1'b0) begin errors++; $display("FAIL rst_wr_prdy got %b want 0", wr_prdy); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_ram_re got %b want 0", ram_re); end
    commit();
    drive(1'b1, rand_word(), 1'b0);
    checks++; if (rd_pvld !== 1'b0) begin errors++; $display("FAIL rst_rd_pvld got %b want 0", rd_pvld); end
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL rst_fifo_cnt got %0d want 0", fifo_cnt); end
    commit();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);
    checks++; if (wr_prdy !== 1'b1) begin errors++; $display("FAIL post_rst_wr_prdy got %b want 1", wr_prdy); end
    checks++; if (rd_pvld !== 1'b0 || ram_re !== 1'b0 || fifo_cnt !== 5'd0) begin
      errors++; $display("FAIL post_rst_idle got pvld=%b re=%b cnt=%0d want 0/0/0", rd_pvld, ram_re, fifo_cnt);
    end
    commit();
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    int lat;
    w = '0;
    w[0] = 1'b1;
    lat = 0;
    drive(1'b1, w, 1'b1);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_ram_we got %b want 1", ram_we); end
    commit();
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, '0, 1'b1);
      if (c == 1) begin
        checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL single_issue got %b want 1", ram_re); end
      end
      if (rd_pvld === 1'b1) begin
        lat = c;
        checks++; if (rd_pd !== w) begin errors++; $display("FAIL single_data got %h want %h", rd_pd, w); end
      end
      commit();
      if (lat != 0) break;
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat); end
    drive(1'b0, '0, 1'b1);
    checks++; if (fifo_cnt !== 5'd0) begin errors++; $display("FAIL single_empty_cnt got %0d want 0", fifo_cnt); end
    commit();
  endtask

  task automatic test_fill_drain();
    int accepted = 0;
    int re_cnt = 0;
    int popped = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, rand_word(), 1'b0);
      if (wr_prdy) accepted++;
      if (ram_re) re_cnt++;
      checks++; if (fifo_cnt !== 5'(model_q.size())) begin errors++; $display("FAIL fill_cnt got %0d want %0d", fifo_cnt, model_q.size()); end
      commit();
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (accepted != 18) begin errors++; $display("FAIL fill_accepted got %0d want 18", accepted); end
    checks++; if (wr_prdy !== 1'b0 || fifo_cnt !== 5'd18) begin errors++; $display("FAIL full_state got prdy=%b cnt=%0d want 0/18", wr_prdy, fifo_cnt); end
    checks++; if (re_cnt != 2) begin errors++; $display("FAIL fill_reads got %0d want 2", re_cnt); end
    commit();
    for (int c = 0; c < 40 && model_q.size() != 0; c++) begin
      drive(1'b0, '0, 1'b1);
      if (rd_pvld === 1'b1) begin
        popped++;
        checks++; if (rd_pd !== model_q[0]) begin errors++; $display("FAIL drain_data got %h want %h", rd_pd, model_q[0]); end
      end
      checks++; if (fifo_cnt !== 5'(model_q.size())) begin errors++; $display("FAIL drain_cnt got %0d want %0d", fifo_cnt, model_q.size()); end
      commit();
    end
    checks++; if (popped != 18) begin errors++; $display("FAIL drain_count got %0d want 18", popped); end
  endtask

  task automatic test_stream();
    int pushed = 0;
    int popped = 0;
    int gaps = 0;
    for (int c = 0; c < 130 && popped < 100; c++) begin
      drive(pushed < 100, rand_word(), 1'b1);
      if (wr_pvld && wr_prdy) pushed++;
      if (rd_pvld === 1'b1) begin
        popped++;
        checks++; if (rd_pd !== model_q[0]) begin errors++; $display("FAIL stream_data got %h want %h", rd_pd, model_q[0]); end
      end else if (popped > 0) gaps++;
      commit();
    end
    checks++; if (popped != 100) begin errors++; $display("FAIL stream_count got %0d want 100", popped); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
  endtask

  task automatic test_full_pop_push();
    logic [AW-1:0] slot_a;
    int popped = 0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, rand_word(), 1'b0);
      commit();
    end
    drive(1'b1, rand_word(), 1'b1);
    slot_a = ram_ra;
    checks++; if (fifo_cnt !== 5'd18 || ram_re !== 1'b1 || wr_prdy !== 1'b0) begin
      errors++; $display("FAIL fullpop_issue got cnt=%0d re=%b prdy=%b want 18/1/0", fifo_cnt, ram_re, wr_prdy);
    end
    checks++; if (rd_pd !== model_q[0]) begin errors++; $display("FAIL fullpop_data got %h want %h", rd_pd, model_q[0]); end
    commit();
    drive(1'b1, rand_word(), 1'b0);
    checks++; if (wr_prdy !== 1'b1 || ram_we !== 1'b1 || ram_wa !== slot_a) begin
      errors++; $display("FAIL reuse_slot got prdy=%b we=%b wa=%0d want 1/1/%0d", wr_prdy, ram_we, ram_wa, slot_a);
    end
    commit();
    for (int c = 0; c < 40 && model_q.size() != 0; c++) begin
      drive(1'b0, '0, 1'b1);
      if (rd_pvld === 1'b1) begin
        popped++;
        checks++; if (rd_pd !== model_q[0]) begin errors++; $display("FAIL reuse_order got %h want %h", rd_pd, model_q[0]); end
      end
      commit();
    end
    checks++; if (popped != 18 || fifo_cnt !== 5'd0) begin errors++; $display("FAIL reuse_drain got %0d/cnt %0d want 18/0", popped, fifo_cnt); end
  endtask

  task automatic test_random();
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 3) == 0 ? 0 : (c % 64 < 20 ? 0 : 1)));
      if (stalled) begin
        checks++; if (rd_pvld !== 1'b1 || rd_pd !== held) begin errors++; $display("FAIL stall_hold got pvld=%b %h want 1 %h", rd_pvld, rd_pd, held); end
      end
      if (rd_pvld === 1'b1 && rd_prdy) begin
        checks++; if (model_q.size() == 0 || rd_pd !== model_q[0]) begin errors++; $display("FAIL rand_data got %h", rd_pd); end
      end
      checks++; if (fifo_cnt !== 5'(model_q.size())) begin errors++; $display("FAIL rand_cnt got %0d want %0d", fifo_cnt, model_q.size()); end
      stalled = rd_pvld && !rd_prdy;
      held = rd_pd;
      commit();
    end
    for (int c = 0; c < 40 && model_q.size() != 0; c++) begin
      drive(1'b0, '0, 1'b1);
      if (rd_pvld === 1'b1) begin
        checks++; if (rd_pd !== model_q[0]) begin errors++; $display("FAIL rand_drain got %h want %h", rd_pd, model_q[0]); end
      end
      commit();
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (model_q.size() != 0 || fifo_cnt !== 5'd0) begin errors++; $display("FAIL rand_empty got cnt=%0d left=%0d want 0/0", fifo_cnt, model_q.size()); end
    commit();
  endtask

  task automatic test_reset_inflight();
    logic [DW-1:0] new_w;
    int got = 0;
    drive(1'b1, rand_word(), 1'b0);
    commit();
    drive(1'b0, '0, 1'b0);
    checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL inflight_issue got %b want 1", ram_re); end
    commit();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    commit();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (rd_pvld !== 1'b0 || fifo_cnt !== 5'd0) begin errors++; $display("FAIL inflight_drop got pvld=%b cnt=%0d want 0/0", rd_pvld, fifo_cnt); end
      commit();
    end
    new_w = rand_word();
    drive(1'b1, new_w, 1'b1);
    commit();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, '0, 1'b1);
      if (rd_pvld === 1'b1) begin
        got++;
        checks++; if (rd_pd !== new_w) begin errors++; $display("FAIL after_rst_data got %h want %h", rd_pd, new_w); end
      end
      commit();
    end
    checks++; if (got != 1) begin errors++; $display("FAIL after_rst_count got %0d want 1", got); end
  endtask

  initial begin
    reset   = 1'b1;
    wr_pvld = 1'b0;
    wr_pd   = '0;
    rd_prdy = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_full_pop_push();
    test_random();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
